// File: rtl/control_pipeline.sv
// Pipelined control unit for the 5-stage MIPS core: decodes IF/ID, carries control
// through ID/EX, EX/MEM and MEM/WB, and resolves hazards, forwarding, bne and j/jal.
module control_pipeline #(
  parameter int ALU_CMD_W  = 3,
  parameter int RA_W       = 5,
  parameter int EN_FORWARD = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           op,
  input  logic [5:0]           funct,
  input  logic [RA_W-1:0]      rs_ID,
  input  logic [RA_W-1:0]      rt_ID,
  input  logic [RA_W-1:0]      rd_ID,
  input  logic                 zero_MEM,
  output logic                 stall_IF,
  output logic                 stall_ID,
  output logic                 flush_ID,
  output logic                 jump_ID,
  output logic                 pcSrc_MEM,
  output logic [ALU_CMD_W-1:0] aluControl_EX,
  output logic                 aluSrc_EX,
  output logic [1:0]           fwdA_EX,
  output logic [1:0]           fwdB_EX,
  output logic                 memWrite_MEM,
  output logic                 regWrite_WB,
  output logic                 memToReg_WB,
  output logic                 link_WB,
  output logic [RA_W-1:0]      writeReg_WB
);

  localparam logic [ALU_CMD_W-1:0] ALU_CMD_ADD = ALU_CMD_W'(3'b010);
  localparam logic [ALU_CMD_W-1:0] ALU_CMD_SUB = ALU_CMD_W'(3'b110);
  localparam logic [ALU_CMD_W-1:0] ALU_CMD_SLT = ALU_CMD_W'(3'b111);
  localparam logic [ALU_CMD_W-1:0] ALU_CMD_XOR = ALU_CMD_W'(3'b011);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  typedef struct packed {
    logic                 regWrite;
    logic                 memToReg;
    logic                 memWrite;
    logic                 branch;
    logic                 aluSrc;
    logic                 link;
    logic [ALU_CMD_W-1:0] aluControl;
    logic [RA_W-1:0]      writeReg;
    logic [RA_W-1:0]      rs;
    logic [RA_W-1:0]      rt;
  } idExT;

  typedef struct packed {
    logic            regWrite;
    logic            memToReg;
    logic            memWrite;
    logic            branch;
    logic            link;
    logic [RA_W-1:0] writeReg;
  } exMemT;

  typedef struct packed {
    logic            regWrite;
    logic            memToReg;
    logic            link;
    logic [RA_W-1:0] writeReg;
  } memWbT;

  idExT  dec, bubbleEx, exNext, ex;
  exMemT memNext, mem;
  memWbT wb;
  logic  isJump, usesRs, usesRt;
  logic  taken, matchEx, matchMem, loadUse, rawStall, stallReq;

  // Source fields a decoded instruction does not read are zeroed, so they can never
  // match a destination and raise a spurious stall or forward.
  always_comb begin
    dec            = '0;
    dec.aluControl = ALU_CMD_ADD;
    isJump         = 1'b0;
    usesRs         = 1'b0;
    usesRt         = 1'b0;
    case (op)
      OP_RTYPE: begin
        if (funct == FN_ADD || funct == FN_SUB || funct == FN_SLT) begin
          dec.regWrite   = 1'b1;
          dec.writeReg   = rd_ID;
          dec.aluControl = (funct == FN_ADD) ? ALU_CMD_ADD :
                           (funct == FN_SUB) ? ALU_CMD_SUB : ALU_CMD_SLT;
          usesRs         = 1'b1;
          usesRt         = 1'b1;
        end
      end
      OP_LW: begin
        dec.regWrite = 1'b1;
        dec.memToReg = 1'b1;
        dec.aluSrc   = 1'b1;
        dec.writeReg = rt_ID;
        usesRs       = 1'b1;
      end
      OP_SW: begin
        dec.memWrite = 1'b1;
        dec.aluSrc   = 1'b1;
        usesRs       = 1'b1;
        usesRt       = 1'b1;
      end
      OP_BNE: begin
        dec.branch     = 1'b1;
        dec.aluControl = ALU_CMD_SUB;
        usesRs         = 1'b1;
        usesRt         = 1'b1;
      end
      OP_XORI: begin
        dec.regWrite   = 1'b1;
        dec.aluSrc     = 1'b1;
        dec.aluControl = ALU_CMD_XOR;
        dec.writeReg   = rt_ID;
        usesRs         = 1'b1;
      end
      OP_ADDI: begin
        dec.regWrite = 1'b1;
        dec.aluSrc   = 1'b1;
        dec.writeReg = rt_ID;
        usesRs       = 1'b1;
      end
      OP_J: isJump = 1'b1;
      OP_JAL: begin
        isJump       = 1'b1;
        dec.regWrite = 1'b1;
        dec.link     = 1'b1;
        dec.writeReg = RA_W'(31);
      end
      default: ;
    endcase
    dec.rs = usesRs ? rs_ID : '0;
    dec.rt = usesRt ? rt_ID : '0;
  end

  assign matchEx  = ex.regWrite && (ex.writeReg != '0) &&
                    ((dec.rs == ex.writeReg) || (dec.rt == ex.writeReg));
  assign matchMem = mem.regWrite && (mem.writeReg != '0) &&
                    ((dec.rs == mem.writeReg) || (dec.rt == mem.writeReg));
  assign loadUse  = ex.memToReg && matchEx;
  assign rawStall = (EN_FORWARD == 0) && (matchEx || matchMem);
  assign taken    = mem.branch && !zero_MEM;

  // A taken branch squashes whatever was stalling, and reset masks every request.
  assign stallReq  = (loadUse || rawStall) && !taken && !reset;
  assign pcSrc_MEM = taken && !reset;
  assign jump_ID   = isJump && !stallReq && !taken && !reset;
  assign flush_ID  = pcSrc_MEM || jump_ID;
  assign stall_IF  = stallReq;
  assign stall_ID  = stallReq;

  always_comb begin
    bubbleEx            = '0;
    bubbleEx.aluControl = ALU_CMD_ADD;
    exNext              = (taken || stallReq) ? bubbleEx : dec;
    memNext             = '0;
    if (!taken) begin
      memNext.regWrite = ex.regWrite;
      memNext.memToReg = ex.memToReg;
      memNext.memWrite = ex.memWrite;
      memNext.branch   = ex.branch;
      memNext.link     = ex.link;
      memNext.writeReg = ex.writeReg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex  <= bubbleEx;
      mem <= '0;
      wb  <= '0;
    end else begin
      ex  <= exNext;
      mem <= memNext;
      wb  <= '{regWrite: mem.regWrite, memToReg: mem.memToReg,
               link: mem.link, writeReg: mem.writeReg};
    end
  end

  // The MEM result is younger than the WB result, so it wins when both match.
  always_comb begin
    fwdA_EX = 2'b00;
    fwdB_EX = 2'b00;
    if (EN_FORWARD != 0) begin
      if (mem.regWrite && mem.writeReg != '0 && mem.writeReg == ex.rs)
        fwdA_EX = 2'b10;
      else if (wb.regWrite && wb.writeReg != '0 && wb.writeReg == ex.rs)
        fwdA_EX = 2'b01;
      if (mem.regWrite && mem.writeReg != '0 && mem.writeReg == ex.rt)
        fwdB_EX = 2'b10;
      else if (wb.regWrite && wb.writeReg != '0 && wb.writeReg == ex.rt)
        fwdB_EX = 2'b01;
    end
  end

  assign aluControl_EX = ex.aluControl;
  assign aluSrc_EX     = ex.aluSrc;
  assign memWrite_MEM  = mem.memWrite;
  assign regWrite_WB   = wb.regWrite;
  assign memToReg_WB   = wb.memToReg;
  assign link_WB       = wb.link;
  assign writeReg_WB   = wb.writeReg;

endmodule

// File: tb/tb_control_pipeline.sv
// Scoreboard bench for control_pipeline: two instances (forwarding and stalling) run
// against an instruction-level model of the pipeline fed by directed then random code.
module tb_control_pipeline;

  localparam int NCYC = 3000;
  localparam logic [2:0] ADD = 3'b010, SUB = 3'b110, SLT = 3'b111, XOR = 3'b011;
  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BNE = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_XORI = 6'h0E, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_SLT = 6'h2A;

  typedef struct packed {
    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
  } instrT;

  typedef struct packed {
    bit       rw;
    bit       m2r;
    bit       mw;
    bit       br;
    bit       asrc;
    bit       link;
    bit       jump;
    bit [2:0] alu;
    bit [4:0] dest;
    bit [4:0] rs;
    bit [4:0] rt;
  } recT;

  logic       clk;
  logic       reset;
  logic [5:0] opS[2], fnS[2];
  logic [4:0] rsS[2], rtS[2], rdS[2];
  logic       zeroS[2];
  logic       stIF[2], stID[2], fl[2], jp[2], pcs[2], asrc[2], mw[2], rw[2], m2r[2], lk[2];
  logic [2:0] alu[2];
  logic [1:0] fa[2], fb[2];
  logic [4:0] wr[2];

  // Instance 0 forwards, instance 1 resolves RAW hazards by stalling.
  for (genvar g = 0; g < 2; g++) begin : gDut
    control_pipeline #(.ALU_CMD_W(3), .RA_W(5), .EN_FORWARD(g == 0 ? 1 : 0)) dut (
      .clk(clk), .reset(reset), .op(opS[g]), .funct(fnS[g]),
      .rs_ID(rsS[g]), .rt_ID(rtS[g]), .rd_ID(rdS[g]), .zero_MEM(zeroS[g]),
      .stall_IF(stIF[g]), .stall_ID(stID[g]), .flush_ID(fl[g]), .jump_ID(jp[g]),
      .pcSrc_MEM(pcs[g]), .aluControl_EX(alu[g]), .aluSrc_EX(asrc[g]),
      .fwdA_EX(fa[g]), .fwdB_EX(fb[g]), .memWrite_MEM(mw[g]),
      .regWrite_WB(rw[g]), .memToReg_WB(m2r[g]), .link_WB(lk[g]), .writeReg_WB(wr[g]));
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [21:0] expQ0[$], expQ1[$];
  int nVec = 0, nMiss = 0;
  recT   pipe[2][3];
  instrT idReg[2];
  instrT prog[$];
  int    pIdx[2];

  function automatic recT bubbleRec();
    recT r = '0;
    r.alu = ADD;
    return r;
  endfunction

  // Instruction semantics: what it writes, what it reads, how it uses the ALU.
  function automatic recT decode(instrT i);
    recT r = bubbleRec();
    bit  readS = 0, readT = 0;
    case (i.op)
      OP_R: if (i.funct == FN_ADD || i.funct == FN_SUB || i.funct == FN_SLT) begin
        r.rw = 1; r.dest = i.rd; readS = 1; readT = 1;
        r.alu = (i.funct == FN_ADD) ? ADD : (i.funct == FN_SUB) ? SUB : SLT;
      end
      OP_LW:   begin r.rw = 1; r.m2r = 1; r.asrc = 1; r.dest = i.rt; readS = 1; end
      OP_SW:   begin r.mw = 1; r.asrc = 1; readS = 1; readT = 1; end
      OP_BNE:  begin r.br = 1; r.alu = SUB; readS = 1; readT = 1; end
      OP_XORI: begin r.rw = 1; r.asrc = 1; r.alu = XOR; r.dest = i.rt; readS = 1; end
      OP_ADDI: begin r.rw = 1; r.asrc = 1; r.dest = i.rt; readS = 1; end
      OP_J:    r.jump = 1;
      OP_JAL:  begin r.jump = 1; r.rw = 1; r.link = 1; r.dest = 5'd31; end
      default: ;
    endcase
    r.rs = readS ? i.rs : 5'd0;
    r.rt = readT ? i.rt : 5'd0;
    return r;
  endfunction

  function automatic bit readsResultOf(recT younger, recT older);
    return older.rw && older.dest != 0 &&
           ((younger.rs == older.dest) || (younger.rt == older.dest));
  endfunction

  function automatic logic [1:0] fwdSel(bit [4:0] src, recT inMem, recT inWb);
    if (src != 0 && inMem.rw && inMem.dest == src) return 2'b10;
    if (src != 0 && inWb.rw && inWb.dest == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic instrT mk(logic [5:0] o, logic [5:0] f, logic [4:0] s,
                               logic [4:0] t, logic [4:0] d);
    return '{op: o, funct: f, rs: s, rt: t, rd: d};
  endfunction

  function automatic logic [4:0] pickReg();
    int r = $urandom_range(4);
    return (r == 4) ? 5'd31 : 5'(r);
  endfunction

  function automatic instrT randInstr();
    instrT i;
    i.rs = pickReg(); i.rt = pickReg(); i.rd = pickReg(); i.funct = 6'($urandom);
    case ($urandom_range(11))
      0: begin i.op = OP_R; i.funct = FN_ADD; end
      1: begin i.op = OP_R; i.funct = FN_SUB; end
      2: begin i.op = OP_R; i.funct = FN_SLT; end
      3: i.op = OP_R;
      4: i.op = OP_LW;
      5: i.op = OP_SW;
      6: i.op = OP_BNE;
      7: i.op = OP_XORI;
      8: i.op = OP_ADDI;
      9: i.op = OP_J;
      10: i.op = OP_JAL;
      default: i.op = 6'($urandom);
    endcase
    return i;
  endfunction

  function automatic logic [21:0] dutVec(int k);
    return {stIF[k], stID[k], fl[k], jp[k], pcs[k], alu[k], asrc[k], fa[k], fb[k],
            mw[k], rw[k], m2r[k], lk[k], wr[k]};
  endfunction

  task automatic applyStimulus(input int k, input bit pushIt, output recT nxt[3],
                               output instrT nxtId);
    recT d, ex, mm, wbR;
    bit  taken, stall, jump, flush;
    logic [21:0] v;
    ex = pipe[k][0]; mm = pipe[k][1]; wbR = pipe[k][2];
    zeroS[k] = 1'($urandom_range(1));
    opS[k] = idReg[k].op; fnS[k] = idReg[k].funct;
    rsS[k] = idReg[k].rs; rtS[k] = idReg[k].rt; rdS[k] = idReg[k].rd;
    d     = decode(idReg[k]);
    taken = mm.br && !zeroS[k] && !reset;
    stall = !taken && !reset &&
            ((ex.m2r && readsResultOf(d, ex)) ||
             (k == 1 && (readsResultOf(d, ex) || readsResultOf(d, mm))));
    jump  = d.jump && !stall && !taken && !reset;
    flush = taken || jump;
    v = {stall, stall, flush, jump, taken, ex.alu, ex.asrc,
         (k == 0) ? fwdSel(ex.rs, mm, wbR) : 2'b00,
         (k == 0) ? fwdSel(ex.rt, mm, wbR) : 2'b00,
         mm.mw, wbR.rw, wbR.m2r, wbR.link, wbR.dest};
    if (pushIt) begin
      if (k == 0) expQ0.push_back(v);
      else expQ1.push_back(v);
    end
    if (reset) begin
      nxt[0] = bubbleRec(); nxt[1] = bubbleRec(); nxt[2] = bubbleRec();
      nxtId = idReg[k];
    end else begin
      nxt[2] = mm;
      nxt[1] = taken ? bubbleRec() : ex;
      nxt[0] = (taken || stall) ? bubbleRec() : d;
      if (flush) nxtId = '0;
      else if (stall) nxtId = idReg[k];
      else if (pIdx[k] < prog.size()) begin
        nxtId = prog[pIdx[k]];
        pIdx[k]++;
      end else nxtId = randInstr();
    end
  endtask

  task automatic checkOutput(input int k, input logic [21:0] expV);
    logic [21:0] got = dutVec(k);
    nVec++;
    if (got !== expV) begin
      nMiss++;
      $display("[TB] FAIL outputs dut%0d t=%0t: got %b required %b", k, $time, got, expV);
    end
  endtask

  // Monitor: every cycle the DUT presents a full control vector at mid-cycle.
  always @(negedge clk) begin
    if (expQ0.size() > 0) checkOutput(0, expQ0.pop_front());
    if (expQ1.size() > 0) checkOutput(1, expQ1.pop_front());
  end

  initial begin
    recT   nxt0[3], nxt1[3];
    instrT id0, id1;
    // lw $8 sits in IF/ID during reset; the directed code then covers load-use,
    // forward priority, $0, an unknown op, jal and bne before random code takes over.
    prog.push_back(mk(OP_R, FN_ADD, 5'd8, 5'd10, 5'd9));
    prog.push_back(mk(OP_R, FN_ADD, 5'd1, 5'd2, 5'd8));
    prog.push_back(mk(OP_R, FN_ADD, 5'd3, 5'd4, 5'd8));
    prog.push_back(mk(OP_R, FN_SUB, 5'd8, 5'd8, 5'd11));
    prog.push_back(mk(OP_LW, 6'h04, 5'd1, 5'd0, 5'd0));
    prog.push_back(mk(OP_R, FN_ADD, 5'd0, 5'd0, 5'd5));
    prog.push_back(mk(6'h3F, 6'h3F, 5'd1, 5'd2, 5'd3));
    prog.push_back(mk(OP_JAL, 6'h10, 5'd1, 5'd2, 5'd3));
    for (int i = 0; i < 3; i++) prog.push_back('0);
    prog.push_back(mk(OP_BNE, 6'h02, 5'd1, 5'd2, 5'd0));
    prog.push_back(mk(OP_R, FN_ADD, 5'd1, 5'd1, 5'd6));
    prog.push_back(mk(OP_BNE, 6'h02, 5'd6, 5'd1, 5'd0));
    for (int k = 0; k < 2; k++) begin
      idReg[k] = mk(OP_LW, 6'h00, 5'd1, 5'd8, 5'd0);
      pIdx[k] = 0;
      for (int s = 0; s < 3; s++) pipe[k][s] = bubbleRec();
    end
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      reset = (cyc < 2) || (cyc >= 60 && $urandom_range(49) == 0);
      applyStimulus(0, cyc > 0, nxt0, id0);
      applyStimulus(1, cyc > 0, nxt1, id1);
      @(posedge clk);
      pipe[0] = nxt0; pipe[1] = nxt1;
      idReg[0] = id0; idReg[1] = id1;
      #1;
    end
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end

endmodule
